// File: rtl/float_pkg.sv
// rtl/float_pkg.sv - shared float format sizing, bias and field-position helpers
package float_pkg;

  function automatic int float_size(input int exp_w, input int mant_w);
    return 1 + exp_w + mant_w;
  endfunction

  // bias_offset > 0 scales the result down by 2**bias_offset (fixed-point input)
  function automatic int exp_bias(input int exp_w, input int bias_offset);
    return (1 << (exp_w - 1)) - 1 - bias_offset;
  endfunction

  function automatic int exp_lsb(input int mant_w);
    return mant_w;
  endfunction

  function automatic int sign_pos(input int exp_w, input int mant_w);
    return exp_w + mant_w;
  endfunction

endpackage

// File: rtl/leading_zero_count.sv
// rtl/leading_zero_count.sv - leading-zero count; all-zero input returns WIDTH
module leading_zero_count #(
  parameter int WIDTH = 32,
  localparam int CW = $clog2(WIDTH + 1)
) (
  input  logic [WIDTH-1:0] value,
  output logic [CW-1:0]    count
);

  // scanning upward lets the highest set bit win
  always_comb begin
    count = CW'(WIDTH);
    for (int i = 0; i < WIDTH; i++) begin
      if (value[i]) count = CW'(WIDTH - 1 - i);
    end
  end

endmodule

// File: rtl/int_to_float.sv
// rtl/int_to_float.sv - 3-stage signed integer to float converter
// Define INT_TO_FLOAT_ROUND_EN for round-to-nearest-even; default truncates toward zero.
module int_to_float import float_pkg::*; #(
  parameter int MANTISSA_SIZE        = 23,
  parameter int EXPONENT_SIZE        = 8,
  parameter int INT_SIZE             = 32,
  parameter int EXPONENT_BIAS_OFFSET = 0,
  localparam int FLOAT_SIZE = float_size(EXPONENT_SIZE, MANTISSA_SIZE)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [INT_SIZE-1:0]   in,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [FLOAT_SIZE-1:0] out
);

  localparam int LZW      = $clog2(INT_SIZE + 1);
  localparam int BIAS     = exp_bias(EXPONENT_SIZE, EXPONENT_BIAS_OFFSET);
  localparam int EXP_MAX  = (1 << EXPONENT_SIZE) - 2;
  localparam int EXP_LSB  = exp_lsb(MANTISSA_SIZE);
  localparam int SIGN_POS = sign_pos(EXPONENT_SIZE, MANTISSA_SIZE);
  localparam int WIDE     = INT_SIZE + MANTISSA_SIZE + 2;

  logic                  advance;
  logic                  valid1_q, valid1_d, valid2_q, valid2_d, out_valid_q, out_valid_d;
  logic                  sign1_q, sign1_d, sign2_q, sign2_d, zero2_q, zero2_d;
  logic [INT_SIZE-1:0]   mag1_q, mag1_d, norm2_q, norm2_d;
  logic [LZW-1:0]        lzc, lzc2_q, lzc2_d;
  logic [FLOAT_SIZE-1:0] out_q, out_d, pack;
  logic [WIDE-1:0]       wide;
  logic [MANTISSA_SIZE-1:0] mant, mant_fin;
  logic [MANTISSA_SIZE:0]   mant_sum;
  logic                  round_up;
  int                    exp_b;

  leading_zero_count #(.WIDTH(INT_SIZE)) u_lzc (
    .value (mag1_q),
    .count (lzc)
  );

  always_comb begin
    advance  = !out_valid_q || out_ready;
    in_ready = advance || reset;

    // norm2_q has its leading one at the MSB; bits below the mantissa feed rounding
    wide = {norm2_q, {(MANTISSA_SIZE + 2){1'b0}}};
    mant = MANTISSA_SIZE'(wide >> (INT_SIZE + 1));
`ifdef INT_TO_FLOAT_ROUND_EN
    round_up = wide[INT_SIZE] & (wide[INT_SIZE-1] | (|wide[INT_SIZE-2:0]) | mant[0]);
`else
    round_up = 1'b0;
`endif
    mant_sum = {1'b0, mant} + {{MANTISSA_SIZE{1'b0}}, round_up};
    mant_fin = mant_sum[MANTISSA_SIZE-1:0];
    exp_b    = INT_SIZE - 1 - int'(lzc2_q) + BIAS + int'(mant_sum[MANTISSA_SIZE]);

    pack = '0;
    if (!zero2_q) begin
      pack[SIGN_POS] = sign2_q;
      if (exp_b > EXP_MAX) begin
        pack[SIGN_POS-1:EXP_LSB] = '1;
      end else if (exp_b >= 1) begin
        pack[SIGN_POS-1:EXP_LSB] = EXPONENT_SIZE'(exp_b);
        pack[EXP_LSB-1:0]        = mant_fin;
      end
    end

    valid1_d    = advance ? in_valid : valid1_q;
    sign1_d     = advance ? in[INT_SIZE-1] : sign1_q;
    mag1_d      = advance ? (in[INT_SIZE-1] ? -in : in) : mag1_q;
    valid2_d    = advance ? valid1_q : valid2_q;
    sign2_d     = advance ? sign1_q : sign2_q;
    zero2_d     = advance ? (mag1_q == '0) : zero2_q;
    lzc2_d      = advance ? lzc : lzc2_q;
    norm2_d     = advance ? (mag1_q << lzc) : norm2_q;
    out_valid_d = advance ? valid2_q : out_valid_q;
    out_d       = advance ? pack : out_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid1_q    <= 1'b0;
      valid2_q    <= 1'b0;
      out_valid_q <= 1'b0;
      out_q       <= '0;
    end else begin
      valid1_q    <= valid1_d;
      valid2_q    <= valid2_d;
      out_valid_q <= out_valid_d;
      out_q       <= out_d;
    end
  end

  always_ff @(posedge clk) begin
    sign1_q <= sign1_d;
    mag1_q  <= mag1_d;
    sign2_q <= sign2_d;
    zero2_q <= zero2_d;
    lzc2_q  <= lzc2_d;
    norm2_q <= norm2_d;
  end

  assign out_valid = out_valid_q;
  assign out       = out_q;

endmodule
